// File: rtl/irq_controller.sv
// Interrupt controller: synchronizes and edge-detects NUM_SRC lines, latches them as pending,
// and runs the request/acknowledge/return handshake with pipeline_control.
module irq_controller #(
  parameter int              NUM_SRC  = 4,
  parameter int              PC_W     = 10,
  parameter logic [PC_W-1:0] VEC_BASE = 10'h3F8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_in,
  input  logic               int_en,
  input  logic               pipe_ready,
  input  logic               int_ack,
  input  logic               int_done,
  input  logic               mask_we,
  input  logic [NUM_SRC-1:0] mask_wdata,
  output logic               interrupt,
  output logic [PC_W-1:0]    int_vector,
  output logic [2:0]         int_id,
  output logic               int_taken,
  output logic [NUM_SRC-1:0] pending,
  output logic               in_service
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_SERVICE} state_t;

  state_t             state;
  logic [2:0]         sel_id;
  logic [NUM_SRC-1:0] s1, s2, s3;
  logic [NUM_SRC-1:0] mask;
  logic [NUM_SRC-1:0] edge_det, clr_vec, cand;
  logic [2:0]         win_id;

  assign edge_det = s2 & ~s3;
  assign cand     = pending & ~mask;

  // Lowest index wins: scan downward so the last hit is the smallest index.
  always_comb begin
    win_id = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--)
      if (cand[i]) win_id = 3'(i);
  end

  always_comb begin
    clr_vec = '0;
    for (int i = 0; i < NUM_SRC; i++)
      clr_vec[i] = (state == S_REQ) && int_ack && (sel_id == 3'(i));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1      <= '0;
      s2      <= '0;
      s3      <= '0;
      mask    <= '1;
      pending <= '0;
    end else begin
      s1      <= irq_in;
      s2      <= s1;
      s3      <= s2;
      if (mask_we) mask <= mask_wdata;
      // A new edge on the same cycle as the ack clear must not be lost.
      pending <= (pending & ~clr_vec) | edge_det;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      sel_id    <= '0;
      int_taken <= 1'b0;
    end else begin
      int_taken <= 1'b0;
      case (state)
        S_IDLE: begin
          if (int_en && pipe_ready && |cand) begin
            sel_id <= win_id;
            state  <= S_REQ;
          end
        end
        S_REQ: begin
          if (int_ack) begin
            int_taken <= 1'b1;
            state     <= S_SERVICE;
          end else if (!int_en) begin
            state <= S_IDLE;
          end
        end
        S_SERVICE: begin
          if (int_done) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign interrupt  = (state == S_REQ);
  assign in_service = (state == S_SERVICE);
  assign int_id     = (state == S_IDLE) ? 3'd0 : sel_id;
  assign int_vector = (state == S_REQ) ? VEC_BASE + PC_W'(sel_id) : '0;

endmodule

// File: tb/tb_irq_controller.sv
// Directed, table-driven bench for irq_controller (NUM_SRC=4, PC_W=10, VEC_BASE=10'h3F8).
module tb_irq_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] irq_in;
  logic       int_en, pipe_ready, int_ack, int_done, mask_we;
  logic [3:0] mask_wdata;
  logic       interrupt, int_taken, in_service;
  logic [9:0] int_vector;
  logic [2:0] int_id;
  logic [3:0] pending;

  int errors = 0;
  int checks = 0;

  irq_controller #(.NUM_SRC(4), .PC_W(10), .VEC_BASE(10'h3F8)) dut (
    .clk(clk), .reset(reset), .irq_in(irq_in), .int_en(int_en), .pipe_ready(pipe_ready),
    .int_ack(int_ack), .int_done(int_done), .mask_we(mask_we), .mask_wdata(mask_wdata),
    .interrupt(interrupt), .int_vector(int_vector), .int_id(int_id), .int_taken(int_taken),
    .pending(pending), .in_service(in_service)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] irq;
    logic       en, pr, ack, done, mwe;
    logic [3:0] mwd;
    logic       intr;
    logic [9:0] vec;
    logic [2:0] id;
    logic       tk;
    logic [3:0] pend;
    logic       insv;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(logic [3:0] irq, logic en, logic pr, logic ack, logic done,
                             logic mwe, logic [3:0] mwd, logic intr, logic [9:0] vec,
                             logic [2:0] id, logic tk, logic [3:0] pend, logic insv);
    vec_t r;
    r.irq = irq; r.en = en; r.pr = pr; r.ack = ack; r.done = done; r.mwe = mwe; r.mwd = mwd;
    r.intr = intr; r.vec = vec; r.id = id; r.tk = tk; r.pend = pend; r.insv = insv;
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Packed snapshot of all outputs: {intr, vec, id, taken, pending, in_service}
  function automatic logic [31:0] outs();
    return 32'({interrupt, int_vector, int_id, int_taken, pending, in_service});
  endfunction

  initial begin
    //        irq    en pr ak dn mwe mwd   | intr vec    id tk pend  insv
    tbl.push_back(v(4'b0000,1,1,0,0,1,4'b0000, 0,10'h000,0,0,4'b0000,0)); // 0 unmask all
    tbl.push_back(v(4'b0100,1,1,0,0,0,4'b0000, 0,10'h000,0,0,4'b0000,0)); // 1 s1
    tbl.push_back(v(4'b0100,1,1,0,0,0,4'b0000, 0,10'h000,0,0,4'b0000,0)); // 2 s2
    tbl.push_back(v(4'b0100,1,1,0,0,0,4'b0000, 0,10'h000,0,0,4'b0100,0)); // 3 pending
    tbl.push_back(v(4'b0100,1,1,0,0,0,4'b0000, 1,10'h3FA,2,0,4'b0100,0)); // 4 REQ
    tbl.push_back(v(4'b0100,1,1,1,0,0,4'b0000, 0,10'h000,2,1,4'b0000,1)); // 5 ack
    tbl.push_back(v(4'b0100,1,1,0,0,0,4'b0000, 0,10'h000,2,0,4'b0000,1)); // 6
    tbl.push_back(v(4'b0100,1,1,0,1,0,4'b0000, 0,10'h000,0,0,4'b0000,0)); // 7 done
    tbl.push_back(v(4'b1110,1,1,0,0,0,4'b0000, 0,10'h000,0,0,4'b0000,0)); // 8 raise 1,3
    tbl.push_back(v(4'b1110,1,1,0,0,0,4'b0000, 0,10'h000,0,0,4'b0000,0)); // 9
    tbl.push_back(v(4'b1110,1,1,0,0,0,4'b0000, 0,10'h000,0,0,4'b1010,0)); // 10
    tbl.push_back(v(4'b1110,1,1,0,0,0,4'b0000, 1,10'h3F9,1,0,4'b1010,0)); // 11 src1 first
    tbl.push_back(v(4'b1110,1,1,1,0,0,4'b0000, 0,10'h000,1,1,4'b1000,1)); // 12
    tbl.push_back(v(4'b1110,1,1,0,1,0,4'b0000, 0,10'h000,0,0,4'b1000,0)); // 13 done
    tbl.push_back(v(4'b1110,1,1,0,0,0,4'b0000, 1,10'h3FB,3,0,4'b1000,0)); // 14 src3
    tbl.push_back(v(4'b1110,0,1,0,0,0,4'b0000, 0,10'h000,0,0,4'b1000,0)); // 15 withdraw
    tbl.push_back(v(4'b1110,0,1,1,0,0,4'b0000, 0,10'h000,0,0,4'b1000,0)); // 16 stray ack
    tbl.push_back(v(4'b1110,1,0,0,0,0,4'b0000, 0,10'h000,0,0,4'b1000,0)); // 17 not ready
    tbl.push_back(v(4'b1110,1,1,0,0,0,4'b0000, 1,10'h3FB,3,0,4'b1000,0)); // 18 reissue
    tbl.push_back(v(4'b1110,1,1,1,0,0,4'b0000, 0,10'h000,3,1,4'b0000,1)); // 19
    tbl.push_back(v(4'b1110,1,1,0,1,0,4'b0000, 0,10'h000,0,0,4'b0000,0)); // 20
    tbl.push_back(v(4'b1110,1,1,0,0,1,4'b0001, 0,10'h000,0,0,4'b0000,0)); // 21 mask src0
    tbl.push_back(v(4'b1111,1,1,0,0,0,4'b0000, 0,10'h000,0,0,4'b0000,0)); // 22 raise 0
    tbl.push_back(v(4'b1111,1,1,0,0,0,4'b0000, 0,10'h000,0,0,4'b0000,0)); // 23
    tbl.push_back(v(4'b1111,1,1,0,0,0,4'b0000, 0,10'h000,0,0,4'b0001,0)); // 24 masked
    tbl.push_back(v(4'b1111,1,1,0,0,0,4'b0000, 0,10'h000,0,0,4'b0001,0)); // 25
    tbl.push_back(v(4'b1111,1,1,0,0,1,4'b0000, 0,10'h000,0,0,4'b0001,0)); // 26 unmask
    tbl.push_back(v(4'b1111,1,1,0,0,0,4'b0000, 1,10'h3F8,0,0,4'b0001,0)); // 27
    tbl.push_back(v(4'b1111,1,1,1,0,0,4'b0000, 0,10'h000,0,1,4'b0000,1)); // 28
    tbl.push_back(v(4'b1110,1,1,0,0,0,4'b0000, 0,10'h000,0,0,4'b0000,1)); // 29 drop 0
    tbl.push_back(v(4'b1110,1,1,0,0,0,4'b0000, 0,10'h000,0,0,4'b0000,1)); // 30
    tbl.push_back(v(4'b1110,1,1,0,0,0,4'b0000, 0,10'h000,0,0,4'b0000,1)); // 31
    tbl.push_back(v(4'b1111,1,1,0,0,0,4'b0000, 0,10'h000,0,0,4'b0000,1)); // 32 re-raise
    tbl.push_back(v(4'b1111,1,1,0,0,0,4'b0000, 0,10'h000,0,0,4'b0000,1)); // 33
    tbl.push_back(v(4'b1111,1,1,0,0,0,4'b0000, 0,10'h000,0,0,4'b0001,1)); // 34 no nesting
    tbl.push_back(v(4'b1111,1,1,0,1,0,4'b0000, 0,10'h000,0,0,4'b0001,0)); // 35 done
    tbl.push_back(v(4'b1111,1,1,0,0,0,4'b0000, 1,10'h3F8,0,0,4'b0001,0)); // 36
    tbl.push_back(v(4'b1110,1,1,0,1,0,4'b0000, 1,10'h3F8,0,0,4'b0001,0)); // 37 stray done
    tbl.push_back(v(4'b1110,1,1,0,0,0,4'b0000, 1,10'h3F8,0,0,4'b0001,0)); // 38
    tbl.push_back(v(4'b1110,1,1,0,0,0,4'b0000, 1,10'h3F8,0,0,4'b0001,0)); // 39
    tbl.push_back(v(4'b1111,1,1,0,0,0,4'b0000, 1,10'h3F8,0,0,4'b0001,0)); // 40
    tbl.push_back(v(4'b1111,1,1,0,0,0,4'b0000, 1,10'h3F8,0,0,4'b0001,0)); // 41
    tbl.push_back(v(4'b1111,1,1,1,0,0,4'b0000, 0,10'h000,0,1,4'b0001,1)); // 42 set beats clear
    tbl.push_back(v(4'b1111,1,1,0,1,0,4'b0000, 0,10'h000,0,0,4'b0001,0)); // 43
    tbl.push_back(v(4'b1111,1,1,0,0,0,4'b0000, 1,10'h3F8,0,0,4'b0001,0)); // 44

    reset = 1'b1; irq_in = '0; int_en = 1'b0; pipe_ready = 1'b0;
    int_ack = 1'b0; int_done = 1'b0; mask_we = 1'b0; mask_wdata = '0;
    #12;
    chk("rst_interrupt",  32'(interrupt),  32'd0);
    chk("rst_int_vector", 32'(int_vector), 32'd0);
    chk("rst_int_id",     32'(int_id),     32'd0);
    chk("rst_int_taken",  32'(int_taken),  32'd0);
    chk("rst_pending",    32'(pending),    32'd0);
    chk("rst_in_service", 32'(in_service), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    foreach (tbl[k]) begin
      @(negedge clk);
      irq_in = tbl[k].irq; int_en = tbl[k].en; pipe_ready = tbl[k].pr;
      int_ack = tbl[k].ack; int_done = tbl[k].done;
      mask_we = tbl[k].mwe; mask_wdata = tbl[k].mwd;
      @(posedge clk); #1;
      chk($sformatf("vec%0d", k), outs(),
          32'({tbl[k].intr, tbl[k].vec, tbl[k].id, tbl[k].tk, tbl[k].pend, tbl[k].insv}));
    end

    // Enter SERVICE with source 3 pending, then reset asynchronously mid-cycle.
    @(negedge clk); int_ack = 1'b1; int_done = 1'b0;
    @(negedge clk); int_ack = 1'b0; irq_in = 4'b0000;
    repeat (2) @(negedge clk);
    irq_in = 4'b1000;
    repeat (3) @(negedge clk);
    chk("svc_in_service", 32'(in_service), 32'd1);
    chk("svc_pending",    32'(pending),    32'b1000);
    #2 reset = 1'b1;
    #1;
    chk("async_in_service", 32'(in_service), 32'd0);
    chk("async_interrupt",  32'(interrupt),  32'd0);
    chk("async_pending",    32'(pending),    32'd0);
    chk("async_int_id",     32'(int_id),     32'd0);
    @(negedge clk); reset = 1'b0;
    // After reset the mask is all ones again, so a fresh edge pends but never requests.
    repeat (5) @(negedge clk);
    chk("post_pending",   32'(pending),   32'b1000);
    chk("post_interrupt", 32'(interrupt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/irq_controller.md
# irq_controller

Interrupt controller for the pipelined RAT core. It synchronizes and edge-detects up to `NUM_SRC` external interrupt lines and holds them in a pending register with a software mask. It picks the highest-priority unmasked source and drives the single `interrupt` request into `pipeline_control`. It then sequences the request/acknowledge/return handshake and supplies the vector address for the PC mux.

## Interface
- `NUM_SRC`, default 4: number of interrupt sources, 1..8.
- `PC_W`, default 10: program counter width.
- `VEC_BASE`, default 10'h3F8: vector of source 0. Source i vectors to `VEC_BASE + i`, truncated to `PC_W` bits.

Ports:
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high; clears all state.
- `irq_in` input NUM_SRC: asynchronous interrupt lines, rising-edge sensitive.
- `int_en` input 1: CPU interrupt-enable (I) flag.
- `pipe_ready` input 1: pipeline can accept an interrupt this cycle (hazard FSM in CHECK).
- `int_ack` input 1: one-cycle pulse when the pipeline enters its INT0 state.
- `int_done` input 1: one-cycle pulse when RETIE/RETID retires.
- `mask_we` input 1: write strobe for the mask register.
- `mask_wdata` input NUM_SRC: new mask value; 1 = source disabled.
- `interrupt` output 1: request to pipeline_control.
- `int_vector` output PC_W: vector address; valid while `interrupt`=1.
- `int_id` output 3: index of the source being requested or serviced.
- `int_taken` output 1: one-cycle pulse on accepted acknowledge; clears the I flag.
- `pending` output NUM_SRC: pending register, readable via IN port.
- `in_service` output 1: a handler is active.

## Operation
- Synchronizer: 2-flop chain per source (`s1`, `s2`), plus a history flop `s3`. An edge is `s2 & ~s3`.
- Pending register:
  - Bit i sets on an edge of source i.
  - Bit i clears on the `int_ack` cycle when `sel_id` = i.
  - Simultaneous set and clear on the same bit: set wins.
  - Masked sources still latch pending; the mask only gates arbitration.
- Candidates = `pending & ~mask`. Fixed priority: lowest index wins.
- FSM states IDLE, REQ, SERVICE:
  - IDLE: if `int_en && pipe_ready && |candidates`, latch the winner into `sel_id` and go to REQ.
  - REQ: `interrupt`=1 and `int_vector` = `VEC_BASE + sel_id`.
    - If `int_ack`: clear `pending[sel_id]`, pulse `int_taken`, go to SERVICE.
    - Else if `!int_en`: withdraw and go to IDLE; the pending bit is retained.
    - `sel_id` stays frozen in REQ, even if a higher-priority source arrives.
  - SERVICE: `in_service`=1. No new request is issued (no nesting). `int_done` returns the FSM to IDLE.
- `int_ack` or `int_done` arriving in a state that does not expect it is ignored.
- `mask_we` updates the mask on the next edge in any state. It does not cancel a request already in REQ.
- `int_id` = `sel_id` in REQ and SERVICE, 0 in IDLE.

## Timing
- Reset values:
  - `interrupt`, `int_taken`, `in_service` = 0.
  - `int_vector` = 0, `int_id` = 0, `pending` = 0.
  - mask = all ones (all masked), FSM = IDLE, sync flops = 0.
- All outputs are registered or decoded from registered state only; there are no combinational paths from inputs to outputs.
- Latency from `irq_in` rising (setup met before edge 1), source unmasked, `int_en`=`pipe_ready`=1:
  - `s2`=1 after edge 2.
  - `pending` bit set after edge 3.
  - FSM in REQ and `interrupt`=1 after edge 4.
- `int_ack` sampled at edge N: `int_taken`=1 during cycle N+1, `interrupt`=0 from N+1.
- `int_done` at edge M: IDLE from M+1. The earliest next `interrupt` is M+2 if a candidate is waiting.
- Reset mid-operation (REQ or SERVICE): all outputs drop asynchronously to reset values, and pending edges are lost.
- A pulse on `irq_in` shorter than one clock may be missed; sources must hold for at least 2 cycles.

## Test plan
- Reset, write mask 4'b0000, raise `irq_in[2]` → `pending`=4'b0100 after edge 3; `interrupt`=1, `int_vector`=10'h3FA, `int_id`=2 after edge 4.
- Raise `irq_in[1]` and `irq_in[3]` in the same cycle, ack, then `int_done` → source 1 is served first (vector 10'h3F9). Source 3 is requested 2 cycles after `int_done`.
- Hold in REQ and drop `int_en` before `int_ack` → `interrupt` deasserts the next cycle, `pending` bit stays 1. Re-raise `int_en` → the request is reissued.
- Mask = 4'b0001, raise `irq_in[0]` → `pending[0]`=1, no `interrupt`. Write mask 0 → `interrupt` one cycle after the write.
- During SERVICE, raise `irq_in[0]` → pending set, no request until `int_done`. The pending set and the ack clear on the same edge leave the bit set.
- Assert `reset` asynchronously while in SERVICE → `in_service`, `interrupt`, and `pending` are 0 before the next clock edge.
